// File: rtl/alu_mext_seq.sv
// alu_mext_seq: handshaked EX-stage ALU with iterative shift-add multiplier and restoring divider
module alu_mext_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    input  logic [4:0]      aluop,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] opr_res
);
    localparam int CW = SHW + 1;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t            r_state, w_state_nx;
    logic [XLEN-1:0]   r_res, r_mp;
    logic [2*XLEN-1:0] r_acc, r_mc;
    logic [CW-1:0]     r_cnt;
    logic              r_neg, r_neg_r, r_hi;
    logic              w_accept, w_is_mul, w_is_div, w_rem_op, w_sgn_a_op, w_sgn_b_op;
    logic              w_sa, w_sb, w_dz, w_ovf, w_iter_div, w_hi_sel, w_ge, w_last;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_base, w_div_fast, w_fast_res, w_q, w_r, w_fin;
    logic [2*XLEN-1:0] w_mul_acc, w_div_acc, w_prod;
    logic [XLEN:0]     w_sh, w_diff;
    assign w_is_mul   = aluop >= 5'd10 && aluop <= 5'd13;
    assign w_is_div   = aluop >= 5'd14 && aluop <= 5'd17;
    assign w_rem_op   = aluop == 5'd16 || aluop == 5'd17;
    assign w_sgn_a_op = aluop == 5'd11 || aluop == 5'd12 || aluop == 5'd14 || aluop == 5'd16;
    assign w_sgn_b_op = aluop == 5'd11 || aluop == 5'd14 || aluop == 5'd16;
    assign w_sa       = w_sgn_a_op && opr_a[XLEN-1];
    assign w_sb       = w_sgn_b_op && opr_b[XLEN-1];
    assign w_mag_a    = w_sa ? -opr_a : opr_a;
    assign w_mag_b    = w_sb ? -opr_b : opr_b;
    assign w_dz       = opr_b == '0;
    assign w_ovf      = (aluop == 5'd14 || aluop == 5'd16) && opr_a == {1'b1, {(XLEN-1){1'b0}}} && &opr_b;
    assign w_iter_div = w_is_div && !w_dz && !w_ovf;
    assign w_hi_sel   = (w_is_mul && aluop != 5'd10) || w_rem_op;
    assign w_div_fast = w_dz ? (w_rem_op ? opr_a : '1) : (w_rem_op ? '0 : opr_a);
    assign w_fast_res = w_is_div ? w_div_fast : w_base;
    always_comb begin
        w_base = '0;
        case (aluop)
            5'd0: w_base = opr_a + opr_b;
            5'd1: w_base = opr_a - opr_b;
            5'd2: w_base = opr_a << opr_b[SHW-1:0];
            5'd3: w_base = {{(XLEN-1){1'b0}}, $signed(opr_a) < $signed(opr_b)};
            5'd4: w_base = {{(XLEN-1){1'b0}}, opr_a < opr_b};
            5'd5: w_base = opr_a ^ opr_b;
            5'd6: w_base = opr_a >> opr_b[SHW-1:0];
            5'd7: w_base = $signed(opr_a) >>> opr_b[SHW-1:0];
            5'd8: w_base = opr_a | opr_b;
            5'd9: w_base = opr_a & opr_b;
            default: w_base = '0;
        endcase
    end
    // Multiply: add shifted multiplicand when the current multiplier bit is set
    assign w_mul_acc = r_acc + (r_mp[0] ? r_mc : '0);
    // Divide: hi half is the partial remainder, lo half shifts dividend out / quotient in
    assign w_sh      = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff    = w_sh - {1'b0, r_mc[XLEN-1:0]};
    assign w_ge      = ~w_diff[XLEN];
    assign w_div_acc = {w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0], r_acc[XLEN-2:0], w_ge};
    assign w_prod    = r_neg ? -w_mul_acc : w_mul_acc;
    assign w_q       = r_neg ? -w_div_acc[XLEN-1:0] : w_div_acc[XLEN-1:0];
    assign w_r       = r_neg_r ? -w_div_acc[2*XLEN-1:XLEN] : w_div_acc[2*XLEN-1:XLEN];
    assign w_fin     = r_state == MUL ? (r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0]) : (r_hi ? w_r : w_q);
    assign w_last    = r_cnt == CW'(1);
    assign in_ready  = !rst && (r_state == IDLE || (r_state == DONE && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_state == DONE;
    assign opr_res   = r_res;
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE, DONE: w_state_nx = w_accept ? (w_is_mul ? MUL : w_iter_div ? DIV : DONE)
                                   : (r_state == DONE && out_ready) ? IDLE : r_state;
            default:    w_state_nx = w_last ? DONE : r_state;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res   <= '0;
            r_acc   <= '0;
            r_mc    <= '0;
            r_mp    <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= CW'(XLEN);
            r_neg   <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_hi    <= w_hi_sel;
            r_acc   <= w_is_mul ? '0 : {{XLEN{1'b0}}, w_mag_a};
            r_mc    <= {{XLEN{1'b0}}, w_is_mul ? w_mag_a : w_mag_b};
            r_mp    <= w_mag_b;
            if (!w_is_mul && !w_iter_div) r_res <= w_fast_res;
        end else if (r_state == MUL || r_state == DIV) begin
            r_acc <= r_state == MUL ? w_mul_acc : w_div_acc;
            r_mc  <= r_state == MUL ? r_mc << 1 : r_mc;
            r_mp  <= r_mp >> 1;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) r_res <= w_fin;
        end
    end
endmodule

// File: tb/tb_alu_mext_seq.sv
// tb_alu_mext_seq: randomized + directed scoreboard bench against an arithmetic reference model
module tb_alu_mext_seq;
    localparam int XLEN = 32;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [31:0] opr_a = '0, opr_b = '0, opr_res;
    logic [4:0]  aluop = '0;
    int          checks = 0, errors = 0, cyc = 0;
    bit          lat_seen = 0, bp_en = 0;
    typedef struct {
        logic [31:0] val;
        int          lat;
        int          acc;
        logic [4:0]  op;
    } exp_t;
    exp_t q[$];
    alu_mext_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opr_a(opr_a), .opr_b(opr_b), .aluop(aluop),
        .out_valid(out_valid), .out_ready(out_ready), .opr_res(opr_res)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     p;
        bit              ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return {31'b0, sa < sb};
            5'd4:  return {31'b0, a < b};
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return 32'(sa >>> b[4:0]);
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: begin p = 64'(sa * sb); return p[31:0]; end
            5'd11: begin p = 64'(sa * sb); return p[63:32]; end
            5'd12: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            5'd13: begin p = ua * ub; return p[63:32]; end
            5'd14: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            5'd15: return b == 0 ? 32'hFFFF_FFFF : a / b;
            5'd16: return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
            5'd17: return b == 0 ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction
    function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 5'd10 && op <= 5'd13) return XLEN + 1;
        if (op >= 5'd14 && op <= 5'd17)
            return (b == 0 || ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : XLEN + 1;
        return 1;
    endfunction
    // Called shortly after a rising edge; returns #1 after the accepting edge
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit push = 1);
        int n = 0;
        aluop = op; opr_a = a; opr_b = b; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("issue_timeout in_ready", {31'b0, in_ready}, 32'h1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) q.push_back('{val: model(op, a, b), lat: exp_lat(op, a, b), acc: cyc, op: op});
        in_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_size", 32'(q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (q.size() == 0) chk("unexpected_out_valid", {31'b0, out_valid}, 32'h0);
                else begin
                    if (!lat_seen) begin
                        lat_seen = 1;
                        chk($sformatf("latency op%0d", q[0].op), 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
                    end
                    if (out_ready) begin
                        chk($sformatf("result op%0d", q[0].op), opr_res, q[0].val);
                        void'(q.pop_front());
                        lat_seen = 0;
                    end
                end
            end
        end
    end
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int t0;
        logic [4:0]  op;
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        chk("reset out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset in_ready", {31'b0, in_ready}, 32'h0);
        chk("reset opr_res", opr_res, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        issue(5'd0, 32'hFFFF_FFFF, 32'h1);
        t0 = cyc;
        issue(5'd7, 32'h8000_0000, 32'h4);
        issue(5'd3, 32'hFFFF_FFFF, 32'h1);
        issue(5'd4, 32'hFFFF_FFFF, 32'h1);
        chk("back_to_back cycles", 32'(cyc - t0), 32'h3);
        issue(5'd1, 32'h5, 32'h7);
        issue(5'd2, 32'h1, 32'h1F);
        issue(5'd6, 32'h8000_0000, 32'h1F);
        issue(5'd5, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(5'd8, 32'hF0F0_0000, 32'h0000_0F0F);
        issue(5'd9, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(5'd20, 32'h1234, 32'h5678);
        drain();
        issue(5'd10, 32'h7, 32'h6);
        issue(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(5'd12, 32'hFFFF_FFFF, 32'h2);
        issue(5'd14, 32'hFFFF_FFF9, 32'h2);
        issue(5'd16, 32'hFFFF_FFF9, 32'h2);
        issue(5'd15, 32'd100, 32'd7);
        issue(5'd17, 32'd100, 32'd7);
        issue(5'd15, 32'd5, 32'd0);
        issue(5'd17, 32'd5, 32'd0);
        issue(5'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'd14, 32'hFFFF_FFF9, 32'h0);
        issue(5'd16, 32'hFFFF_FFF9, 32'h0);
        drain();
        out_ready = 1'b0;
        issue(5'd10, 32'h1234, 32'h5678);
        t0 = 0;
        while (!out_valid && t0 < 100) begin
            @(negedge clk);
            t0++;
        end
        repeat (5) begin
            @(negedge clk);
            chk("hold out_valid", {31'b0, out_valid}, 32'h1);
            chk("hold in_ready", {31'b0, in_ready}, 32'h0);
            chk("hold opr_res", opr_res, 32'h0626_0060);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(5'd0, 32'd2, 32'd40);
        drain();
        issue(5'd14, 32'd1000, 32'd3, 0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst in_ready", {31'b0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("mid_div_rst out_valid", {31'b0, out_valid}, 32'h0);
        chk("mid_div_rst opr_res", opr_res, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        issue(5'd0, 32'd2, 32'd3);
        drain();
        bp_en = 1;
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 19));
            a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF) : $urandom;
            issue(op, a, b);
        end
        drain();
        bp_en = 0;
        @(posedge clk);
        #3 out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("final queue_empty", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
